// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game: match FSM states, winner codes,
// video geometry and the pixel-clock frequency that timing delays derive from.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int H_VIDEO = 640;
    localparam int V_VIDEO = 480;

    localparam int CLK_FREQ_HZ = 25_175_000;
    // One second of ball hold before each serve.
    localparam int DEFAULT_SERVE_DELAY_CYC = CLK_FREQ_HZ;

endpackage

// File: rtl/button_edge_sync.sv
// Synchronises a raw active-low button into the clk_0 domain and emits a
// one-cycle registered pulse on each press (falling edge of btn_n).
module button_edge_sync (
    input  logic clk_0,
    input  logic rst,
    input  logic btn_n,
    output logic pulse
);

    logic sync_0;
    logic sync_1;
    logic sync_prev;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            sync_0    <= 1'b1;
            sync_1    <= 1'b1;
            sync_prev <= 1'b1;
            pulse     <= 1'b0;
        end else begin
            sync_0    <= btn_n;
            sync_1    <= sync_0;
            sync_prev <= sync_1;
            // High-to-low on the synchronised level; a held button gives one pulse.
            pulse     <= sync_prev & ~sync_1;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve countdown, play/pause, point scoring and game over.
// Gates ball motion and requests ball re-centring for the physics block.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE       = 7,
    parameter int SERVE_DELAY_CYC = DEFAULT_SERVE_DELAY_CYC,
    parameter int CNT_W           = 25,
    parameter int SCORE_W         = 4
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               start_n,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               play_en,
    output logic               serve_load,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY_CYC - 1);

    state_t             state;
    logic [CNT_W-1:0]   delay_cnt;
    logic               start_evt;

    button_edge_sync u_start_sync (
        .clk_0 (clk_0),
        .rst   (rst),
        .btn_n (start_n),
        .pulse (start_evt)
    );

    assign state_o = state;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            play_en    <= 1'b0;
            serve_load <= 1'b0;
            serve_dir  <= 1'b0;
            score_p1   <= '0;
            score_p2   <= '0;
            winner     <= WIN_NONE;
            delay_cnt  <= '0;
        end else begin
            serve_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_evt) begin
                        state      <= ST_SERVE;
                        serve_dir  <= 1'b0;
                        serve_load <= 1'b1;
                        delay_cnt  <= '0;
                    end
                end
                ST_SERVE: begin
                    if (delay_cnt == CNT_LAST) begin
                        state   <= ST_PLAY;
                        play_en <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    // Misses take priority over a coincident start press.
                    if (miss_left && miss_right) begin
                        state      <= ST_SERVE;
                        play_en    <= 1'b0;
                        serve_load <= 1'b1;
                        delay_cnt  <= '0;
                    end else if (miss_left) begin
                        if (score_p2 != WIN_VAL) score_p2 <= score_p2 + SCORE_W'(1);
                        serve_dir <= 1'b0;
                        state     <= ST_POINT;
                        play_en   <= 1'b0;
                    end else if (miss_right) begin
                        if (score_p1 != WIN_VAL) score_p1 <= score_p1 + SCORE_W'(1);
                        serve_dir <= 1'b1;
                        state     <= ST_POINT;
                        play_en   <= 1'b0;
                    end else if (start_evt) begin
                        state   <= ST_PAUSE;
                        play_en <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_evt) begin
                        state   <= ST_PLAY;
                        play_en <= 1'b1;
                    end
                end
                ST_POINT: begin
                    if (score_p1 == WIN_VAL) begin
                        winner <= WIN_P1;
                        state  <= ST_OVER;
                    end else if (score_p2 == WIN_VAL) begin
                        winner <= WIN_P2;
                        state  <= ST_OVER;
                    end else begin
                        state      <= ST_SERVE;
                        serve_load <= 1'b1;
                        delay_cnt  <= '0;
                    end
                end
                ST_OVER: begin
                    if (start_evt) begin
                        score_p1   <= '0;
                        score_p2   <= '0;
                        winner     <= WIN_NONE;
                        serve_dir  <= 1'b0;
                        state      <= ST_SERVE;
                        serve_load <= 1'b1;
                        delay_cnt  <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
